uart_rx_byte_buffer: RTL
========================

# uart_rx_byte_buffer

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each completed frame (`P_DATA` qualified by the `Data_Valid` pulse, with the frame's parity/stop error flags) into a small first-word-fall-through FIFO. It presents the bytes to the system-side consumer with a pop handshake, occupancy status and a sticky overflow flag. This decouples the bit-rate-paced receiver from a consumer that may stall for several frame times.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of a received byte (must match the receiver's `P_DATA`)
- `ADDR_WIDTH`, 3, FIFO address width; depth = 2**`ADDR_WIDTH` entries (≥ 1, so depth ≥ 2)

Ports:
- `CLK`  in  1  single clock, shared with the receiver; all logic on rising edge
- `RST`  in  1  asynchronous, active-high reset
- `Data_Valid`  in  1  one-cycle pulse marking a completed frame
- `P_DATA`  in  `DATA_WIDTH`  received byte, valid while `Data_Valid`=1
- `par_err`  in  1  parity error of the frame, valid while `Data_Valid`=1
- `stp_err`  in  1  stop-bit error of the frame, valid while `Data_Valid`=1
- `RD_EN`  in  1  consumer pop request
- `CLR_OVF`  in  1  clears `OVERFLOW`
- `RD_DATA`  out  `DATA_WIDTH`  head-of-FIFO byte (fall-through)
- `RD_ERR`  out  1  error tag of the head entry (`par_err` | `stp_err` at capture)
- `EMPTY`  out  1  FIFO holds no entries
- `FULL`  out  1  FIFO holds 2**`ADDR_WIDTH` entries
- `COUNT`  out  `ADDR_WIDTH`+1  current occupancy, 0..2**`ADDR_WIDTH`
- `OVERFLOW`  out  1  sticky: a frame was lost because the FIFO was full

## Operation
- Storage: 2**`ADDR_WIDTH` entries of {err tag, byte}. Write pointer, read pointer and count are registered.
- Write: accepted on a rising edge with `Data_Valid`=1 and (not `FULL` or pop in the same cycle). The entry is stored at the write pointer, and the pointer increments modulo depth (natural wrap).
- Pop: occurs on a rising edge with `RD_EN`=1 and `EMPTY`=0. The read pointer increments modulo depth. `RD_EN` while `EMPTY` is ignored: no pointer or flag change.
- Count: +1 on write only, −1 on pop only, unchanged on both or neither. `EMPTY` = (`COUNT`==0), `FULL` = (`COUNT`==depth), both registered-derived with no combinational path from inputs.
- Simultaneous write and pop:
  - when full: both happen, `COUNT` stays at depth, no overflow.
  - when empty: the pop is ignored (`EMPTY`=1 that cycle), the write happens, and `COUNT` becomes 1.
- Overflow: `Data_Valid`=1 while `FULL`=1 and no pop drops the frame and sets `OVERFLOW`=1 on that edge. Stored data is untouched.
- `CLR_OVF`=1 clears `OVERFLOW` on the next edge. If a drop occurs in the same cycle, set wins and `OVERFLOW` stays 1.
- `RD_DATA`/`RD_ERR` are driven directly from the entry at the read pointer. Their value while `EMPTY`=1 is the stale/reset content and is don't-care to the consumer.

## Timing
- Reset (asynchronous, immediate): pointers=0, `COUNT`=0, `EMPTY`=1, `FULL`=0, `OVERFLOW`=0. Storage is cleared to 0, so `RD_DATA`=0 and `RD_ERR`=0.
- Reset asserted mid-operation discards all buffered entries. Outputs return to reset values without waiting for a clock edge.
- Write latency: a frame captured on edge N has `EMPTY`=0 and `RD_DATA`/`RD_ERR` valid after edge N (one cycle).
- Pop latency: after the popping edge, `RD_DATA` shows the next entry in the same cycle as the updated `COUNT`.
- Back-to-back operation: one write and one pop per cycle are sustained indefinitely.

## Configuration
- `UART_RX_BUF_ERR_DROP_EN` defined:
  - A frame with `par_err` or `stp_err` set at `Data_Valid` is discarded. It is not written and does not count toward `COUNT` or `OVERFLOW`.
  - `RD_ERR` is tied to 0.
- Not defined: errored frames are stored normally with the err tag = `par_err` | `stp_err`, visible on `RD_ERR` when at the head.

## Test plan
- Reset, then 3 frames 0xA5, 0x3C, 0xFF with no errors → `COUNT`=3. Pops return 0xA5, 0x3C, 0xFF in order with `RD_ERR`=0, then `EMPTY`=1.
- Fill 8 frames (0x00..0x07, depth 8) → `FULL`=1. A 9th frame 0x08 → `OVERFLOW`=1, contents unchanged. Draining yields 0x00..0x07. `CLR_OVF` pulse → `OVERFLOW`=0.
- With `FULL`=1, `Data_Valid` (0x55) and `RD_EN` in the same cycle → head popped, 0x55 stored, `COUNT` stays 8, `OVERFLOW`=0. The last pop returns 0x55.
- Frame 0x81 with `par_err`=1:
  - without the macro → stored, popped with `RD_ERR`=1.
  - with `UART_RX_BUF_ERR_DROP_EN` → `COUNT` stays 0 and `EMPTY` stays 1.
- `RD_EN` held high while empty for 5 cycles, then one frame 0x42 → no change during the empty cycles. 0x42 appears with `EMPTY`=0 one cycle after capture and is popped on the following edge.
- Load 5 frames, assert `RST` between clock edges → `COUNT`=0, `EMPTY`=1 and `RD_DATA`=0 immediately. Pointer wrap is verified by 20 write/pop pairs with an incrementing pattern.

Source files
------------

// File: rtl/uart_rx_byte_buffer_if.sv
// Consumer/producer handshake bundle for uart_rx_byte_buffer.
// master = receiver + consumer side driving frames and pops; slave = the buffer.
interface uart_rx_byte_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  Data_Valid;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  par_err;
    logic                  stp_err;
    logic                  RD_EN;
    logic                  CLR_OVF;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  RD_ERR;
    logic                  EMPTY;
    logic                  FULL;
    logic [ADDR_WIDTH:0]   COUNT;
    logic                  OVERFLOW;

    modport master (
        output Data_Valid, P_DATA, par_err, stp_err, RD_EN, CLR_OVF,
        input  RD_DATA, RD_ERR, EMPTY, FULL, COUNT, OVERFLOW
    );

    modport slave (
        input  Data_Valid, P_DATA, par_err, stp_err, RD_EN, CLR_OVF,
        output RD_DATA, RD_ERR, EMPTY, FULL, COUNT, OVERFLOW
    );
endinterface

// File: rtl/uart_rx_byte_buffer.sv
// First-word-fall-through byte FIFO behind the UART receiver, with sticky overflow.
// Optional `UART_RX_BUF_ERR_DROP_EN: discard errored frames and force RD_ERR to 0.
module uart_rx_byte_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                        CLK,
    input  logic                        RST,
    uart_rx_byte_buffer_if.slave        bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_ovf;

    logic w_empty;
    logic w_full;
    logic w_err;
    logic w_tag;
    logic w_frame;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));
    assign w_err   = bus.par_err | bus.stp_err;

`ifdef UART_RX_BUF_ERR_DROP_EN
    // Errored frames never reach storage, so the stored tag is always 0.
    assign w_frame = bus.Data_Valid & ~w_err;
    assign w_tag   = 1'b0;
`else
    assign w_frame = bus.Data_Valid;
    assign w_tag   = w_err;
`endif

    assign w_pop  = bus.RD_EN & ~w_empty;
    // When full, a same-cycle pop frees the slot the write pointer aims at.
    assign w_wr   = w_frame & (~w_full | w_pop);
    assign w_drop = w_frame & w_full & ~w_pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= {w_tag, bus.P_DATA};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.CLR_OVF) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.RD_DATA  = r_mem[r_rd_ptr][DATA_WIDTH-1:0];
    assign bus.RD_ERR   = r_mem[r_rd_ptr][DATA_WIDTH];
    assign bus.EMPTY    = w_empty;
    assign bus.FULL     = w_full;
    assign bus.COUNT    = r_count;
    assign bus.OVERFLOW = r_ovf;
endmodule
